// File: rtl/avaliador_ativos_busca_if.sv
// Command/result bundle for the active-node evaluator.
// Master drives commands and accepts results; slave is the evaluator.
interface avaliador_ativos_busca_if #(
    parameter int NUM_NA          = 8,
    parameter int ADR_WIDTH       = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int CRITERIO_WIDTH  = 5
);
    localparam int OCUP_WIDTH = $clog2(NUM_NA + 1);

    logic                       atualizar_in;
    logic                       desativar_in;
    logic [ADR_WIDTH-1:0]       endereco_in;
    logic [ADR_WIDTH-1:0]       anterior_in;
    logic [DISTANCIA_WIDTH-1:0] distancia_in;
    logic [CUSTO_WIDTH-1:0]     menor_vizinho_in;
    logic                       buscar_in;
    logic                       aceito_in;

    logic                       pronto_out;
    logic                       valido_out;
    logic                       vazio_out;
    logic [ADR_WIDTH-1:0]       menor_endereco_out;
    logic [ADR_WIDTH-1:0]       menor_anterior_out;
    logic [DISTANCIA_WIDTH-1:0] menor_distancia_out;
    logic [CRITERIO_WIDTH-1:0]  menor_criterio_out;
    logic [OCUP_WIDTH-1:0]      ocupacao_out;
    logic                       cheio_out;
    logic [1:0]                 erro_out;

    modport master (
        output atualizar_in, desativar_in,
        output endereco_in, anterior_in,
        output distancia_in, menor_vizinho_in,
        output buscar_in, aceito_in,
        input  pronto_out, valido_out, vazio_out,
        input  menor_endereco_out, menor_anterior_out,
        input  menor_distancia_out, menor_criterio_out,
        input  ocupacao_out, cheio_out, erro_out
    );

    modport slave (
        input  atualizar_in, desativar_in,
        input  endereco_in, anterior_in,
        input  distancia_in, menor_vizinho_in,
        input  buscar_in, aceito_in,
        output pronto_out, valido_out, vazio_out,
        output menor_endereco_out, menor_anterior_out,
        output menor_distancia_out, menor_criterio_out,
        output ocupacao_out, cheio_out, erro_out
    );
endinterface

// File: rtl/avaliador_ativos_busca.sv
// Active-node table with sequential minimum-criterion search.
// AVALIADOR_HEURISTICA_EN adds the saturated distance+cost heuristic.
module avaliador_ativos_busca #(
    parameter int NUM_NA          = 8,
    parameter int ADR_WIDTH       = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int CRITERIO_WIDTH  = 5
) (
    input logic clk,
    input logic rst_n,
    avaliador_ativos_busca_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_NA);
    localparam int OCUP_W = $clog2(NUM_NA + 1);
    localparam logic [IDX_W-1:0]  ULTIMO = IDX_W'(NUM_NA - 1);
    localparam logic [OCUP_W-1:0] CAPAC  = OCUP_W'(NUM_NA);

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        RESULTADO
    } estado_t;

    logic                       r_valid [NUM_NA];
    logic [ADR_WIDTH-1:0]       r_end   [NUM_NA];
    logic [ADR_WIDTH-1:0]       r_ant   [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] r_dist  [NUM_NA];
    logic [CRITERIO_WIDTH-1:0]  r_crit  [NUM_NA];

    estado_t                    r_estado;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_achou;
    logic [ADR_WIDTH-1:0]       r_min_end;
    logic [ADR_WIDTH-1:0]       r_min_ant;
    logic [DISTANCIA_WIDTH-1:0] r_min_dist;
    logic [CRITERIO_WIDTH-1:0]  r_min_crit;

    logic                       r_pronto;
    logic                       r_valido;
    logic                       r_vazio;
    logic [ADR_WIDTH-1:0]       r_menor_end;
    logic [ADR_WIDTH-1:0]       r_menor_ant;
    logic [DISTANCIA_WIDTH-1:0] r_menor_dist;
    logic [CRITERIO_WIDTH-1:0]  r_menor_crit;
    logic [OCUP_W-1:0]          r_ocup;
    logic                       r_cheio;
    logic [1:0]                 r_erro;

    logic [CRITERIO_WIDTH-1:0]  w_crit;
    logic                       w_hit;
    logic [IDX_W-1:0]           w_hit_idx;
    logic                       w_free;
    logic [IDX_W-1:0]           w_free_idx;
    logic                       w_cmd;
    logic                       w_atu;
    logic                       w_des;
    logic                       w_busca;
    logic                       w_melhora;
    logic                       w_insere;
    logic                       w_estouro;
    logic                       w_remove;
    logic                       w_descarte;
    logic [OCUP_W-1:0]          w_ocup_nxt;

`ifdef AVALIADOR_HEURISTICA_EN
    logic [CRITERIO_WIDTH:0] w_soma;

    assign w_soma = (CRITERIO_WIDTH+1)'(bus.distancia_in)
                  + (CRITERIO_WIDTH+1)'(bus.menor_vizinho_in);
    assign w_crit = w_soma[CRITERIO_WIDTH] ? '1
                  : w_soma[CRITERIO_WIDTH-1:0];
`else
    assign w_crit = CRITERIO_WIDTH'(bus.distancia_in);
`endif

    // Downward scan so the lowest matching / free index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_NA - 1; i >= 0; i--) begin
            if (r_valid[i] && r_end[i] == bus.endereco_in) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_cmd   = bus.atualizar_in | bus.desativar_in
                   | bus.buscar_in;
    assign w_des   = r_pronto & bus.desativar_in;
    assign w_atu   = r_pronto & bus.atualizar_in
                   & ~bus.desativar_in;
    assign w_busca = r_pronto & bus.buscar_in;

    assign w_melhora = w_atu & w_hit
                     & (w_crit < r_crit[w_hit_idx]);
    assign w_insere  = w_atu & ~w_hit & w_free;
    assign w_estouro = w_atu & ~w_hit & ~w_free;
    assign w_remove  = w_des & w_hit;
    assign w_descarte = (~r_pronto & w_cmd)
                      | (r_pronto & bus.atualizar_in
                         & bus.desativar_in);

    always_comb begin
        w_ocup_nxt = r_ocup;
        if (w_insere)
            w_ocup_nxt = r_ocup + OCUP_W'(1);
        else if (w_remove)
            w_ocup_nxt = r_ocup - OCUP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NA; i++) begin
                r_valid[i] <= 1'b0;
                r_end[i]   <= '0;
                r_ant[i]   <= '0;
                r_dist[i]  <= '0;
                r_crit[i]  <= '0;
            end
        end else begin
            if (w_remove)
                r_valid[w_hit_idx] <= 1'b0;
            if (w_insere) begin
                r_valid[w_free_idx] <= 1'b1;
                r_end[w_free_idx]   <= bus.endereco_in;
                r_ant[w_free_idx]   <= bus.anterior_in;
                r_dist[w_free_idx]  <= bus.distancia_in;
                r_crit[w_free_idx]  <= w_crit;
            end
            if (w_melhora) begin
                r_ant[w_hit_idx]  <= bus.anterior_in;
                r_dist[w_hit_idx] <= bus.distancia_in;
                r_crit[w_hit_idx] <= w_crit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ocup  <= '0;
            r_cheio <= 1'b0;
            r_erro  <= 2'b00;
        end else begin
            r_ocup  <= w_ocup_nxt;
            r_cheio <= (w_ocup_nxt == CAPAC);
            if (w_estouro)
                r_erro[0] <= 1'b1;
            if (w_descarte)
                r_erro[1] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= OCIOSO;
            r_idx        <= '0;
            r_achou      <= 1'b0;
            r_min_end    <= '0;
            r_min_ant    <= '0;
            r_min_dist   <= '0;
            r_min_crit   <= '0;
            r_pronto     <= 1'b0;
            r_valido     <= 1'b0;
            r_vazio      <= 1'b0;
            r_menor_end  <= '0;
            r_menor_ant  <= '0;
            r_menor_dist <= '0;
            r_menor_crit <= '0;
        end else begin
            unique case (r_estado)
                OCIOSO: begin
                    r_pronto <= ~w_busca;
                    if (w_busca) begin
                        r_estado <= BUSCA;
                        r_idx    <= '0;
                        r_achou  <= 1'b0;
                    end
                end
                BUSCA: begin
                    // Strict < keeps the lowest index on ties.
                    if (r_valid[r_idx] &&
                        (!r_achou ||
                         r_crit[r_idx] < r_min_crit)) begin
                        r_achou    <= 1'b1;
                        r_min_end  <= r_end[r_idx];
                        r_min_ant  <= r_ant[r_idx];
                        r_min_dist <= r_dist[r_idx];
                        r_min_crit <= r_crit[r_idx];
                    end
                    if (r_idx == ULTIMO)
                        r_estado <= RESULTADO;
                    else
                        r_idx <= r_idx + IDX_W'(1);
                end
                RESULTADO: begin
                    if (!r_valido) begin
                        r_valido     <= 1'b1;
                        r_vazio      <= ~r_achou;
                        r_menor_end  <= r_achou ? r_min_end  : '0;
                        r_menor_ant  <= r_achou ? r_min_ant  : '0;
                        r_menor_dist <= r_achou ? r_min_dist : '0;
                        r_menor_crit <= r_achou ? r_min_crit : '0;
                    end else if (bus.aceito_in) begin
                        r_valido <= 1'b0;
                        r_pronto <= 1'b1;
                        r_estado <= OCIOSO;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.pronto_out          = r_pronto;
    assign bus.valido_out          = r_valido;
    assign bus.vazio_out           = r_vazio;
    assign bus.menor_endereco_out  = r_menor_end;
    assign bus.menor_anterior_out  = r_menor_ant;
    assign bus.menor_distancia_out = r_menor_dist;
    assign bus.menor_criterio_out  = r_menor_crit;
    assign bus.ocupacao_out        = r_ocup;
    assign bus.cheio_out           = r_cheio;
    assign bus.erro_out            = r_erro;
endmodule
